// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply loader and result-readout stages.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } ldr_state_t;

    // Memory word address: {zero-pad, bank, row[aw-1:0], col[aw-1:0]}.
    // Callers pass row/col already truncated to aw bits.
    function automatic logic [31:0] mm_addr(
        input logic        bank,
        input logic [31:0] row,
        input logic [31:0] col,
        input int unsigned aw
    );
        return (32'(bank) << (2 * aw)) | (row << aw) | col;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// Streams matrix A (bank 0) then matrix B (bank 1) row-major into the
// multiplier memory, waits out the compute latency, then flags results ready.
module matrix_loader
    import mm_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned COMP_LAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] writeAddr,
    output logic [31:0] writeData,
    output logic        busy,
    output logic        load_done,
    output logic        results_ready
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = 2 * AW + 1;
    localparam int unsigned LW = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(2 * N * N - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(COMP_LAT - 1);

    ldr_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rr_q, rr_d;
    logic          beat;

    // Ready depends on state alone so upstream never sees a valid->ready loop.
    assign in_ready = (state_q == LOAD);
    assign beat     = in_valid && in_ready;

    // Next-state, counter and write-stage computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        // An accepted beat always produces its write next cycle, even when
        // abort lands on the same edge.
        if (beat) begin
            we_d   = 1'b1;
            addr_d = mm_addr(cnt_q[2*AW],
                             32'(cnt_q[2*AW-1:AW]),
                             32'(cnt_q[AW-1:0]),
                             AW);
            data_d = in_data;
        end

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (beat) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they track
        // the state register exactly.
        busy_d = (state_d == LOAD) || (state_d == WAIT);
        rr_d   = (state_d == DONE);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
        end
    end

    assign we            = we_q;
    assign writeAddr     = addr_q;
    assign writeData     = data_q;
    assign busy          = busy_q;
    assign load_done     = done_q;
    assign results_ready = rr_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: N=4/COMP_LAT=3 instance plus a default-size instance.
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [31:0] in_data;
    logic        in_ready, we, busy, load_done, results_ready;
    logic [31:0] writeAddr, writeData;

    logic        start32, in_valid32, abort32;
    logic [31:0] in_data32;
    logic        in_ready32, we32, busy32, load_done32, results_ready32;
    logic [31:0] writeAddr32, writeData32;

    always #5 clk = ~clk;

    matrix_loader #(.N(4), .COMP_LAT(3)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .writeAddr(writeAddr), .writeData(writeData),
        .busy(busy), .load_done(load_done), .results_ready(results_ready)
    );

    matrix_loader dut32 (
        .clk(clk), .reset(reset), .start(start32), .abort(abort32),
        .in_valid(in_valid32), .in_data(in_data32), .in_ready(in_ready32),
        .we(we32), .writeAddr(writeAddr32), .writeData(writeData32),
        .busy(busy32), .load_done(load_done32), .results_ready(results_ready32)
    );

    typedef struct {
        logic        start, abort, valid;
        logic [31:0] data;
        logic        e_ready, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_busy, e_ld, e_rr;
    } vec_t;

    vec_t        vt[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wa_q[$], wd_q[$];
    int          ld_cnt;
    logic [31:0] ld_addr;
    int          w32_cnt, ld32_cnt;
    logic [31:0] last_a32, last_d32, ld32_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and log every write strobe seen after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (we) begin
            wa_q.push_back(writeAddr);
            wd_q.push_back(writeData);
        end
        if (load_done) begin
            ld_cnt++;
            ld_addr = writeAddr;
        end
        if (we32) begin
            w32_cnt++;
            last_a32 = writeAddr32;
            last_d32 = writeData32;
        end
        if (load_done32) begin
            ld32_cnt++;
            ld32_addr = writeAddr32;
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ld_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic s, input logic a, input logic v, input logic [31:0] d,
                                input logic rdy, input logic w, input logic [31:0] ea,
                                input logic [31:0] ed, input logic b, input logic ld, input logic rr);
        vec_t r;
        r.start = s; r.abort = a; r.valid = v; r.data = d;
        r.e_ready = rdy; r.e_we = w; r.e_addr = ea; r.e_wdata = ed;
        r.e_busy = b; r.e_ld = ld; r.e_rr = rr;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int k;
        int i;
        logic seen_rr;

        // Vector table: reset-exit, start with in_valid high, stalls, ignored starts,
        // full 32-word load, latency wait, DONE, then abort out of DONE.
        vt.push_back(mk(0, 0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 32'h55, 1, 0, 32'h0, 32'h0, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'h0,  1, 1, 32'h0, 32'h0, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'h1,  1, 1, 32'h1, 32'h1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 32'hAA, 1, 0, 32'h1, 32'h1, 1, 0, 0));
        vt.push_back(mk(1, 0, 1, 32'h2,  1, 1, 32'h2, 32'h2, 1, 0, 0));
        for (int d = 3; d < 32; d++)
            vt.push_back(mk(0, 0, 1, 32'(d), (d != 31), 1, 32'(d), 32'(d), 1, (d == 31), 0));
        vt.push_back(mk(0, 0, 1, 32'h99, 0, 0, 32'h1F, 32'h1F, 1, 0, 0));
        vt.push_back(mk(1, 0, 1, 32'h99, 0, 0, 32'h1F, 32'h1F, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 32'h0,  0, 0, 32'h1F, 32'h1F, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 32'h0,  0, 0, 32'h1F, 32'h1F, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 32'h0,  0, 0, 32'h1F, 32'h1F, 0, 0, 0));

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        start32 = 1'b0; abort32 = 1'b0; in_valid32 = 1'b0; in_data32 = '0;
        w32_cnt = 0; ld32_cnt = 0; last_a32 = '0; last_d32 = '0; ld32_addr = '0;
        clear_log();
        tick();
        tick();

        // Outputs while reset is held.
        chk("rst.ready", 32'(in_ready), 0);
        chk("rst.we", 32'(we), 0);
        chk("rst.addr", writeAddr, 0);
        chk("rst.data", writeData, 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ld", 32'(load_done), 0);
        chk("rst.rr", 32'(results_ready), 0);
        reset = 1'b0;

        // Table-driven cycles.
        for (int unsigned v = 0; v < vt.size(); v++) begin
            start = vt[v].start; abort = vt[v].abort;
            in_valid = vt[v].valid; in_data = vt[v].data;
            tick();
            chk($sformatf("v%0d.ready", v), 32'(in_ready), 32'(vt[v].e_ready));
            chk($sformatf("v%0d.we", v), 32'(we), 32'(vt[v].e_we));
            chk($sformatf("v%0d.addr", v), writeAddr, vt[v].e_addr);
            chk($sformatf("v%0d.wdata", v), writeData, vt[v].e_wdata);
            chk($sformatf("v%0d.busy", v), 32'(busy), 32'(vt[v].e_busy));
            chk($sformatf("v%0d.ld", v), 32'(load_done), 32'(vt[v].e_ld));
            chk($sformatf("v%0d.rr", v), 32'(results_ready), 32'(vt[v].e_rr));
        end
        start = 0; abort = 0; in_valid = 0;

        // Stalled stream: in_valid low every other cycle, start poked mid-load.
        do_reset();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        k = 0;
        while (i < 32 && k < 200) begin
            chk("t2.ready", 32'(in_ready), 1);
            in_valid = (k % 2 == 0);
            in_data  = 32'(i);
            start    = (k == 7);
            tick();
            if (in_valid) i++;
            k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("t2.beats", 32'(i), 32);
        k = 0;
        while (!results_ready && k < 20) begin
            start = (k == 0);
            tick();
            start = 1'b0;
            k++;
        end
        chk("t2.latency", 32'(k), 3);
        chk("t2.nwrites", 32'(wa_q.size()), 32);
        for (int j = 0; j < 32 && j < wa_q.size(); j++) begin
            chk($sformatf("t2.addr%0d", j), wa_q[j], 32'(j));
            chk($sformatf("t2.data%0d", j), wd_q[j], 32'(j));
        end
        chk("t2.ldcnt", 32'(ld_cnt), 1);
        chk("t2.ldaddr", ld_addr, 32'h1F);

        // Start from DONE restarts at bank 0 row 0 col 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.rr_fall", 32'(results_ready), 0);
        chk("t5.busy", 32'(busy), 1);
        chk("t5.ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        chk("t5.we", 32'(we), 1);
        chk("t5.addr", writeAddr, 32'h0);
        chk("t5.data", writeData, 32'hDEAD);

        // Abort after 10 beats with nothing pending.
        do_reset();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + b);
            tick();
        end
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3.busy", 32'(busy), 0);
        chk("t3.ready", 32'(in_ready), 0);
        chk("t3.we", 32'(we), 0);
        for (int b = 0; b < 5; b++) tick();
        chk("t3.nwrites", 32'(wa_q.size()), 10);
        chk("t3.lastaddr", wa_q[wa_q.size()-1], 32'h9);
        chk("t3.ldcnt", 32'(ld_cnt), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h7;
        tick();
        chk("t3.restart_addr", writeAddr, 32'h0);
        in_data = 32'h8;
        tick();
        // Abort on the same edge as an accepted beat: that write still lands.
        in_data = 32'h77;
        abort   = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t3.abw_we", 32'(we), 1);
        chk("t3.abw_addr", writeAddr, 32'h2);
        chk("t3.abw_data", writeData, 32'h77);
        chk("t3.abw_busy", 32'(busy), 0);
        chk("t3.abw_ready", 32'(in_ready), 0);
        tick();
        chk("t3.abw_we_after", 32'(we), 0);

        // Reset during WAIT.
        do_reset();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            in_valid = 1'b1;
            in_data  = 32'(b + 1000);
            tick();
        end
        in_valid = 1'b0;
        chk("t4.ld", 32'(load_done), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4.we", 32'(we), 0);
        chk("t4.addr", writeAddr, 0);
        chk("t4.data", writeData, 0);
        chk("t4.busy", 32'(busy), 0);
        chk("t4.ld0", 32'(load_done), 0);
        chk("t4.ready", 32'(in_ready), 0);
        seen_rr = results_ready;
        for (int b = 0; b < 8; b++) begin
            tick();
            seen_rr = seen_rr | results_ready;
        end
        chk("t4.rr_never", 32'(seen_rr), 0);

        // Default N=32, COMP_LAT=8 instance.
        w32_cnt = 0;
        ld32_cnt = 0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int b = 0; b < 2048; b++) begin
            in_valid32 = 1'b1;
            in_data32  = 32'(b) ^ 32'hA5000000;
            tick();
        end
        in_valid32 = 1'b0;
        chk("t6.ld", 32'(load_done32), 1);
        chk("t6.nwrites", 32'(w32_cnt), 2048);
        chk("t6.lastaddr", last_a32, 32'h7FF);
        chk("t6.lastdata", last_d32, 32'hA50007FF);
        chk("t6.ldaddr", ld32_addr, 32'h7FF);
        k = 0;
        while (!results_ready32 && k < 30) begin
            tick();
            k++;
        end
        chk("t6.latency", 32'(k), 8);
        chk("t6.ldcnt", 32'(ld32_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
